fn1_div_udiv_31ns_17ns_15_seq: RTL and testbench

FN1_DIV_UDIV_31NS_17NS_15_SEQ -- requirements
Module: fn1_div_udiv_31ns_17ns_15_seq

---
 rtl/fn1_udiv_pkg.sv | 25 ++
 rtl/fn1_udiv_step.sv | 33 +++
 rtl/fn1_div_udiv_31ns_17ns_15_seq.sv | 144 ++++++++++++++
 tb/tb_fn1_div_udiv_31ns_17ns_15_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fn1_udiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fn1_udiv_pkg
// Description : Shared widths, counter sizing and FSM state encoding for the
//               sequential 31/17 unsigned divider.
// Revision    : 1.0 - initial release
// ============================================================================
package fn1_udiv_pkg;

  localparam int DIVIDEND_W = 31;              // dividend / full quotient width
  localparam int DIVISOR_W  = 17;              // divisor / remainder width
  localparam int QUOT_W     = 15;              // quotient bits presented on dout
  localparam int PR_W       = DIVISOR_W + 1;   // partial remainder incl. shift-in bit
  localparam int CNT_W      = 5;               // enough to count 30 down to 0

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : fn1_udiv_pkg
`default_nettype wire

// File: rtl/fn1_udiv_step.sv
`default_nettype none
// ============================================================================
// Module      : fn1_udiv_step
// Description : One combinational restoring-division step: shift a dividend
//               bit into the partial remainder and subtract the divisor when
//               that does not borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module fn1_udiv_step
  import fn1_udiv_pkg::*;
(
  input  logic [PR_W-1:0]      pr_i,
  input  logic                 dbit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [PR_W-1:0]      pr_o,
  output logic                 qbit_o
);

  logic [PR_W-1:0] shift_w;
  logic [PR_W:0]   diff_w;
  logic            unused_pr_msb;

  // The MSB is shifted out every step; after a successful subtract the
  // remainder is always below the divisor, so nothing of value is lost.
  assign unused_pr_msb = pr_i[PR_W-1];

  assign shift_w = {pr_i[PR_W-2:0], dbit_i};
  assign diff_w  = {1'b0, shift_w} - {2'b00, divisor_i};
  assign qbit_o  = ~diff_w[PR_W];
  assign pr_o    = qbit_o ? diff_w[PR_W-1:0] : shift_w;

endmodule : fn1_udiv_step
`default_nettype wire

// File: rtl/fn1_div_udiv_31ns_17ns_15_seq.sv
`default_nettype none
// ============================================================================
// Module      : fn1_div_udiv_31ns_17ns_15_seq
// Description : Sequential unsigned divider, 31-bit dividend / 17-bit divisor,
//               one restoring step per enabled cycle. Presents quotient bits
//               [14:0], the remainder, an overflow flag for the upper
//               quotient bits and a divide-by-zero flag.
//               Optional build macro FN1_UDIV_DIV0_CHECK_EN: when defined, a
//               zero divisor bypasses the iteration and finishes in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fn1_div_udiv_31ns_17ns_15_seq
  import fn1_udiv_pkg::*;
#(
  parameter logic [31:0] ID = 32'd1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] din0,
  input  logic [DIVISOR_W-1:0]  din1,
  output logic                  ready,
  output logic                  done,
  output logic [QUOT_W-1:0]     dout,
  output logic [DIVISOR_W-1:0]  rem,
  output logic                  ovf,
  output logic                  div0
);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [DIVIDEND_W-1:0]   dividend_q;
  logic [DIVISOR_W-1:0]    divisor_q;
  logic [PR_W-1:0]         pr_q;
  logic [DIVIDEND_W-1:0]   quot_q;
  logic [QUOT_W-1:0]       dout_q;
  logic [DIVISOR_W-1:0]    rem_q;
  logic                    ovf_q;
  logic                    div0_q;
  logic                    done_q;

  logic [PR_W-1:0]         pr_next_w;
  logic                    qbit_w;
  logic                    div0_start_w;
  logic                    div0_now_w;
  logic [31:0]             unused_id;

  assign unused_id = ID;

`ifdef FN1_UDIV_DIV0_CHECK_EN
  assign div0_start_w = (din1 == '0);
  assign div0_now_w   = (divisor_q == '0);
`else
  assign div0_start_w = 1'b0;
  assign div0_now_w   = 1'b0;
`endif

  fn1_udiv_step u_step (
    .pr_i      (pr_q),
    .dbit_i    (dividend_q[cnt_q]),
    .divisor_i (divisor_q),
    .pr_o      (pr_next_w),
    .qbit_o    (qbit_w)
  );

  // State register; ce freezes the FSM, reset overrides ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else if (ce) begin
      state_q <= state_d;
    end
  end

  // Next-state: accept start only in IDLE, iterate until the counter hits 0.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = div0_start_w ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand capture, restoring iteration and result latching.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      pr_q       <= '0;
      quot_q     <= '0;
      dout_q     <= '0;
      rem_q      <= '0;
      ovf_q      <= 1'b0;
      div0_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (ce) begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dividend_q <= din0;
            divisor_q  <= din1;
            cnt_q      <= CNT_INIT;
            // A zero divisor preloads the saturated result so the DONE
            // state can latch every outcome the same way.
            if (div0_start_w) begin
              quot_q <= '1;
              pr_q   <= {1'b0, din0[DIVISOR_W-1:0]};
            end else begin
              quot_q <= '0;
              pr_q   <= '0;
            end
          end
        end
        S_CALC: begin
          pr_q   <= pr_next_w;
          quot_q <= {quot_q[DIVIDEND_W-2:0], qbit_w};
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        S_DONE: begin
          done_q <= 1'b1;
          dout_q <= quot_q[QUOT_W-1:0];
          rem_q  <= pr_q[DIVISOR_W-1:0];
          ovf_q  <= |quot_q[DIVIDEND_W-1:QUOT_W];
          div0_q <= div0_now_w;
        end
        default: ;
      endcase
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = done_q;
  assign dout  = dout_q;
  assign rem   = rem_q;
  assign ovf   = ovf_q;
  assign div0  = div0_q;

endmodule : fn1_div_udiv_31ns_17ns_15_seq
`default_nettype wire

// File: tb/tb_fn1_div_udiv_31ns_17ns_15_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fn1_div_udiv_31ns_17ns_15_seq
// Description : Directed self-checking bench for the sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fn1_div_udiv_31ns_17ns_15_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        start;
  logic [30:0] din0;
  logic [16:0] din1;
  logic        ready;
  logic        done;
  logic [14:0] dout;
  logic [16:0] rem;
  logic        ovf;
  logic        div0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fn1_div_udiv_31ns_17ns_15_seq #(.ID(32'd1)) dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .start (start),
    .din0  (din0),
    .din1  (din1),
    .ready (ready),
    .done  (done),
    .dout  (dout),
    .rem   (rem),
    .ovf   (ovf),
    .div0  (div0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a division, scramble operands and poke start during the run,
  // optionally drop ce for gap_len cycles, then check latency and results.
  task automatic run_div(input string tag, input logic [30:0] a, input logic [16:0] b,
                         input int gap_at, input int gap_len, input int exp_lat,
                         input logic [14:0] eq, input logic [16:0] er,
                         input logic eo, input logic ed);
    int lat;
    bit seen;
    din0  = a;
    din1  = b;
    start = 1'b1;
    ce    = 1'b1;
    tick();
    start = 1'b0;
    din0  = 31'($urandom);
    din1  = 17'($urandom);
    check({tag, "/busy"}, 32'(ready), 32'd0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      if (lat == gap_at) begin
        ce = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          tick();
          lat++;
          check({tag, "/gap_done"}, 32'(done), 32'd0);
        end
        ce = 1'b1;
      end
      start = (lat == 3);
      tick();
      lat++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/dout"}, 32'(dout), 32'(eq));
    check({tag, "/rem"}, 32'(rem), 32'(er));
    check({tag, "/ovf"}, 32'(ovf), 32'(eo));
    check({tag, "/div0"}, 32'(div0), 32'(ed));
    ce = 1'b0;
    tick();
    tick();
    check({tag, "/done_hold"}, 32'(done), 32'd1);
    ce = 1'b1;
    tick();
    check({tag, "/done_pulse"}, 32'(done), 32'd0);
    check({tag, "/ready_after"}, 32'(ready), 32'd1);
    check({tag, "/dout_stable"}, 32'(dout), 32'(eq));
    check({tag, "/rem_stable"}, 32'(rem), 32'(er));
  endtask

  initial begin
    int done_seen;
    reset = 1'b1;
    ce    = 1'b0;
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    tick();
    tick();
    check("rst/ready", 32'(ready), 32'd1);
    check("rst/done", 32'(done), 32'd0);
    check("rst/dout", 32'(dout), 32'd0);
    check("rst/rem", 32'(rem), 32'd0);
    check("rst/ovf", 32'(ovf), 32'd0);
    check("rst/div0", 32'(div0), 32'd0);
    reset = 1'b0;
    ce    = 1'b1;
    tick();

    run_div("d100_7",   31'd100,        17'd7,      -1, 0, 32, 15'd14,    17'd2,     1'b0, 1'b0);
    run_div("d2e9_1e5", 31'd2000000000, 17'd100000, -1, 0, 32, 15'd20000, 17'd0,     1'b0, 1'b0);
    run_div("dmax_1",   31'd2147483647, 17'd1,      -1, 0, 32, 15'h7FFF,  17'd0,     1'b1, 1'b0);
    run_div("d1e6_max", 31'd1000000,    17'd131071, -1, 0, 32, 15'd7,     17'd82503, 1'b0, 1'b0);
    run_div("d5_9",     31'd5,          17'd9,      -1, 0, 32, 15'd0,     17'd5,     1'b0, 1'b0);
    run_div("ce_gap",   31'd100,        17'd7,      10, 5, 37, 15'd14,    17'd2,     1'b0, 1'b0);

    // Reset in the middle of the iteration must abort without a done pulse.
    din0  = 31'd1000;
    din1  = 17'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort/ready", 32'(ready), 32'd1);
    check("abort/done", 32'(done), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("abort/no_done", 32'(done_seen), 32'd0);
    run_div("after_abort", 31'd100, 17'd7, -1, 0, 32, 15'd14, 17'd2, 1'b0, 1'b0);

`ifdef FN1_UDIV_DIV0_CHECK_EN
    run_div("div0", 31'h12355678, 17'd0, -1, 0, 1, 15'h7FFF, 17'h15678, 1'b1, 1'b1);
`else
    run_div("div0", 31'h12355678, 17'd0, -1, 0, 32, 15'h7FFF, 17'h15678, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fn1_div_udiv_31ns_17ns_15_seq
`default_nettype wire
